// File: rtl/tpg_pkg.sv
// rtl/tpg_pkg.sv - shared mode encodings, box direction and RGB888 colour constants
package tpg_pkg;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_RAMP    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BOX     = 2'd3
    } tpg_mode_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } box_dir_e;

    localparam logic [23:0] RGB_WHITE  = 24'hFFFFFF;
    localparam logic [23:0] RGB_BLACK  = 24'h000000;
    localparam logic [23:0] RGB_RED    = 24'hFF0C00;
    localparam logic [23:0] RGB_GREEN  = 24'h00FF00;
    localparam logic [23:0] RGB_BLUE   = 24'h0000FF;
    localparam logic [23:0] RGB_YELLOW = 24'hFFFF00;
    localparam logic [23:0] RGB_PURPLE = 24'hFF00FF;
    localparam logic [23:0] RGB_CYAN   = 24'h00FFFF;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_BLACK;
            3'd2:    return RGB_RED;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_BLUE;
            3'd5:    return RGB_YELLOW;
            3'd6:    return RGB_PURPLE;
            default: return RGB_CYAN;
        endcase
    endfunction

endpackage

// File: rtl/test_pattern_gen_if.sv
// rtl/test_pattern_gen_if.sv - pixel coordinate in / RGB pixel out bundle
interface test_pattern_gen_if #(
    parameter int X_BITS = 12,
    parameter int Y_BITS = 12
);
    logic [X_BITS-1:0] pix_x;
    logic [Y_BITS-1:0] pix_y;
    logic              de_in;
    logic [1:0]        mode_req;
    logic [1:0]        mode_cur;
    logic [23:0]       pix_data;
    logic              de_out;

    modport master (
        output pix_x, pix_y, de_in, mode_req,
        input  mode_cur, pix_data, de_out
    );

    modport slave (
        input  pix_x, pix_y, de_in, mode_req,
        output mode_cur, pix_data, de_out
    );
endinterface

// File: rtl/tpg_box_ctrl.sv
// rtl/tpg_box_ctrl.sv - per-frame bouncing horizontal position of the moving box
module tpg_box_ctrl
    import tpg_pkg::*;
#(
    parameter int X_BITS   = 12,
    parameter int H_DISP   = 1920,
    parameter int BOX_SIZE = 128,
    parameter int BOX_STEP = 4
) (
    input  logic              pix_clk,
    input  logic              rst_n,
    input  logic              frame_end,
    output logic [X_BITS-1:0] box_x
);

    localparam logic [X_BITS:0] BOX_MAX = (X_BITS+1)'(H_DISP - BOX_SIZE);
    localparam logic [X_BITS:0] STEP    = (X_BITS+1)'(BOX_STEP);

    box_dir_e          dir_q, dir_d;
    logic [X_BITS-1:0] pos_q, pos_d;
    logic [X_BITS:0]   pos_ext;

    assign pos_ext = {1'b0, pos_q};
    assign box_x   = pos_q;

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= DIR_RIGHT;
            pos_q <= '0;
        end else begin
            dir_q <= dir_d;
            pos_q <= pos_d;
        end
    end

    // Direction flips on the same update that lands on a clamp edge.
    always_comb begin
        dir_d = dir_q;
        pos_d = pos_q;
        if (frame_end) begin
            if (dir_q == DIR_RIGHT) begin
                if (pos_ext + STEP >= BOX_MAX) begin
                    pos_d = BOX_MAX[X_BITS-1:0];
                    dir_d = DIR_LEFT;
                end else begin
                    pos_d = pos_q + STEP[X_BITS-1:0];
                end
            end else begin
                if (pos_ext <= STEP) begin
                    pos_d = '0;
                    dir_d = DIR_RIGHT;
                end else begin
                    pos_d = pos_q - STEP[X_BITS-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/test_pattern_gen.sv
// rtl/test_pattern_gen.sv - 2-stage RGB888 test pattern generator; TPG_BORDER_EN adds a white frame border
module test_pattern_gen
    import tpg_pkg::*;
#(
    parameter int X_BITS     = 12,
    parameter int Y_BITS     = 12,
    parameter int H_DISP     = 1920,
    parameter int V_DISP     = 1080,
    parameter int CHK_SHIFT  = 6,
    parameter int RAMP_SHIFT = 3,
    parameter int BOX_SIZE   = 128,
    parameter int BOX_STEP   = 4
) (
    input  logic               pix_clk,
    input  logic               rst_n,
    test_pattern_gen_if.slave  vid
);

    localparam int BAR_W  = H_DISP / 8;
    localparam int BOX_Y0 = (V_DISP - BOX_SIZE) / 2;
    localparam logic [X_BITS-1:0] X_LAST  = X_BITS'(H_DISP - 1);
    localparam logic [Y_BITS-1:0] Y_LAST  = Y_BITS'(V_DISP - 1);
    localparam logic [X_BITS:0]   BOX_W   = (X_BITS+1)'(BOX_SIZE);
    localparam logic [Y_BITS:0]   BOX_TOP = (Y_BITS+1)'(BOX_Y0);
    localparam logic [Y_BITS:0]   BOX_BOT = (Y_BITS+1)'(BOX_Y0 + BOX_SIZE);

    logic              frame_start, frame_end, in_active;
    tpg_mode_e         mode_q, mode_eff, s1_mode;
    logic [X_BITS-1:0] box_x, s1_x;
    logic [Y_BITS-1:0] s1_y;
    logic              s1_de, s1_act;
    logic [2:0]        bar_idx;
    logic [7:0]        gray;
    logic              in_box;
    logic [23:0]       colour, pix_q;
    logic              de_q;

    assign frame_start = vid.de_in && (vid.pix_x == '0) && (vid.pix_y == '0);
    assign frame_end   = vid.de_in && (vid.pix_x == X_LAST) && (vid.pix_y == Y_LAST);
    assign in_active   = vid.de_in && (vid.pix_x <= X_LAST) && (vid.pix_y <= Y_LAST);
    // The frame-start pixel itself already renders with the newly requested mode.
    assign mode_eff    = frame_start ? tpg_mode_e'(vid.mode_req) : mode_q;

    assign vid.mode_cur = mode_q;
    assign vid.pix_data = pix_q;
    assign vid.de_out   = de_q;

    tpg_box_ctrl #(
        .X_BITS   (X_BITS),
        .H_DISP   (H_DISP),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box_ctrl (
        .pix_clk   (pix_clk),
        .rst_n     (rst_n),
        .frame_end (frame_end),
        .box_x     (box_x)
    );

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_BARS;
            s1_mode <= MODE_BARS;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_de   <= 1'b0;
            s1_act  <= 1'b0;
        end else begin
            mode_q  <= mode_eff;
            s1_mode <= mode_eff;
            s1_x    <= vid.pix_x;
            s1_y    <= vid.pix_y;
            s1_de   <= vid.de_in;
            s1_act  <= in_active;
        end
    end

`ifdef TPG_BORDER_EN
    logic s1_border;
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_border <= 1'b0;
        end else begin
            s1_border <= in_active && ((vid.pix_x == '0) || (vid.pix_x == X_LAST) ||
                                       (vid.pix_y == '0) || (vid.pix_y == Y_LAST));
        end
    end
`endif

    // Threshold ladder instead of a divider; columns past the last bar stay cyan.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (s1_x >= X_BITS'(i * BAR_W)) bar_idx = 3'(i);
        end
    end

    assign gray   = 8'(s1_x >> RAMP_SHIFT);
    assign in_box = ({1'b0, s1_x} >= {1'b0, box_x}) &&
                    ({1'b0, s1_x} <  ({1'b0, box_x} + BOX_W)) &&
                    ({1'b0, s1_y} >= BOX_TOP) && ({1'b0, s1_y} < BOX_BOT);

    always_comb begin
        colour = RGB_BLACK;
        case (s1_mode)
            MODE_BARS:    colour = bar_colour(bar_idx);
            MODE_RAMP:    colour = {gray, gray, gray};
            MODE_CHECKER: colour = (s1_x[CHK_SHIFT] ^ s1_y[CHK_SHIFT]) ? RGB_WHITE : RGB_BLACK;
            MODE_BOX:     colour = in_box ? RGB_WHITE : RGB_BLACK;
            default:      colour = RGB_BLACK;
        endcase
`ifdef TPG_BORDER_EN
        if (s1_border) colour = RGB_WHITE;
`endif
        if (!s1_act) colour = RGB_BLACK;
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q <= '0;
            de_q  <= 1'b0;
        end else begin
            pix_q <= colour;
            de_q  <= s1_de;
        end
    end

endmodule

// File: doc/test_pattern_gen.md
TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 SHALL have parameter X_BITS, default 12, horizontal coordinate width.
REQ-002 SHALL have parameter Y_BITS, default 12, vertical coordinate width.
REQ-003 SHALL have parameter H_DISP, default 1920, active pixels per line.
REQ-004 SHALL have parameter V_DISP, default 1080, active lines per frame.
REQ-005 SHALL have parameter CHK_SHIFT, default 6, checkerboard square size = 2^CHK_SHIFT.
REQ-006 SHALL have parameter RAMP_SHIFT, default 3, ramp level = pix_x >> RAMP_SHIFT.
REQ-007 SHALL have parameter BOX_SIZE, default 128, moving box edge length in pixels.
REQ-008 SHALL have parameter BOX_STEP, default 4, box displacement per frame in pixels.
REQ-009 SHALL have port pix_clk, input, 1, pixel clock.
REQ-010 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port pix_x, input, X_BITS, current column.
REQ-012 SHALL have port pix_y, input, Y_BITS, current line.
REQ-013 SHALL have port de_in, input, 1, coordinate valid / active video.
REQ-014 SHALL have port mode_req, input, 2, requested pattern.
REQ-015 SHALL have port mode_cur, output, 2, pattern currently displayed.
REQ-016 SHALL have port pix_data, output, 24, RGB888 pixel.
REQ-017 SHALL have port de_out, output, 1, de_in delayed to align with pix_data.

Function
REQ-018 SHALL have a fixed latency of 2 pix_clk cycles from pix_x/pix_y/de_in to pix_data/de_out.
REQ-019 Mode 0 SHALL output 8 equal vertical bars of width H_DISP/8, in order white, black, red (FF0C00), green, blue, yellow, purple, cyan; columns >= 7*(H_DISP/8) SHALL be cyan.
REQ-020 Mode 1 SHALL output gray R=G=B=(pix_x >> RAMP_SHIFT) modulo 256.
REQ-021 Mode 2 SHALL output white when pix_x[CHK_SHIFT] XOR pix_y[CHK_SHIFT] = 1, else black.
REQ-022 Mode 3 SHALL output white inside a BOX_SIZE square at columns box_x..box_x+BOX_SIZE-1 and lines (V_DISP-BOX_SIZE)/2 onward; black elsewhere.
REQ-023 The box_x register SHALL update once per frame, on the cycle de_in=1, pix_x=H_DISP-1, pix_y=V_DISP-1.
REQ-024 Box motion: moving right, box_x += BOX_STEP, clamped to H_DISP-BOX_SIZE, with direction reversing on reaching the clamp; moving left, box_x -= BOX_STEP, clamped to 0, with direction reversing on reaching 0.
REQ-025 mode_req SHALL be sampled into mode_cur only on the cycle de_in=1, pix_x=0, pix_y=0 (frame start), so a frame never mixes patterns.
REQ-026 That frame-start pixel SHALL already use the new mode.
REQ-027 When de_in=0, or pix_x>=H_DISP, or pix_y>=V_DISP, pix_data SHALL be 000000 and de_out SHALL equal the delayed de_in.
REQ-028 Arithmetic SHALL be unsigned.
REQ-029 Box comparisons SHALL use X_BITS+1 bits, so box_x+BOX_SIZE never wraps.

Reset
REQ-030 On rst_n low, pix_data, de_out and both pipeline stages SHALL clear to 0 asynchronously.
REQ-031 On rst_n low, mode_cur SHALL clear to 0, box_x to 0 and the box direction to right.
REQ-032 A reset mid-frame SHALL discard in-flight pixels.
REQ-033 After reset release, mode 0 SHALL apply until the next frame start.

Configuration
REQ-034 With TPG_BORDER_EN defined, pixels at pix_x=0, pix_x=H_DISP-1, pix_y=0 or pix_y=V_DISP-1 SHALL be white in every mode, overriding the pattern, with unchanged latency.
REQ-035 Without TPG_BORDER_EN, no border logic SHALL exist and the pattern alone SHALL be output.

Structure
REQ-036 The RGB888 colour constants and mode encodings (0 BARS, 1 RAMP, 2 CHECKER, 3 BOX) SHALL live in shared package tpg_pkg.
REQ-037 The box position/direction logic SHALL be sub-module tpg_box_ctrl (inputs: frame-end strobe; output: box_x).

Verification
REQ-038 Reset, mode 0, 1920x1080 frame -> columns 0/240/480/1919 read FFFFFF/000000/FF0C00/00FFFF two cycles after input; de_out tracks de_in delayed by 2.
REQ-039 mode_req 0->2 changed at mid-frame line 500 -> remainder of frame stays bars; next frame (0,0)=000000, (64,0)=FFFFFF, (64,64)=000000.
REQ-040 Mode 1 -> pixel 1919 = 0xEF gray (1919>>3=239); pixel 2047 forced with de_in=1 -> 000000.
REQ-041 Mode 3, run 500 frames -> box_x sequence 0,4,8,...,1792, then 1788,..., never exceeding 1792; pixel (box_x, 476) white, (box_x-1, 476) black.
REQ-042 rst_n pulsed low mid-line in mode 3 -> outputs 0 immediately, box_x=0, mode_cur=0 after release.
REQ-043 With TPG_BORDER_EN, mode 2 -> (0,540), (1919,540), (960,1079) white; without TPG_BORDER_EN, same pixels follow the checkerboard.
